// File: rtl/bath_pkg.sv
// Shared types for the bath transit timer: FSM state encoding and request codes.
package bath_pkg;

  localparam int unsigned REQ_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // req bit1 = depart, bit0 = arrive
  localparam logic [REQ_W-1:0] REQ_NONE = 2'b00;
  localparam logic [REQ_W-1:0] REQ_ARR  = 2'b01;
  localparam logic [REQ_W-1:0] REQ_DEP  = 2'b10;
  localparam logic [REQ_W-1:0] REQ_BAD  = 2'b11;

endpackage

// File: rtl/bath_tick_gen.sv
// Prescaler: registered tick once every DIV cycles after clear drops; clear holds it at zero.
module bath_tick_gen
  import bath_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt;

  // tick is registered one cycle ahead so it is high while cnt sits at DIV-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear || (cnt == PW'(DIV - 1))) begin
      cnt  <= '0;
      tick <= 1'(DIV == 1);
    end else begin
      cnt  <= cnt + PW'(1);
      tick <= 1'((cnt + PW'(1)) == PW'(DIV - 1));
    end
  end

endmodule

// File: rtl/bath_transit_timer.sv
// Qualifies arrive/depart requests that hold steady for DELAY prescaled ticks.
// Optional seven-segment view of count when BATH_TIMER_DISPLAY_EN is defined.
module bath_transit_timer
  import bath_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int DELAY  = 5,
  parameter int DIV    = 1,
  parameter int STICKY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic             departing,
  output logic             arriving,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
`ifdef BATH_TIMER_DISPLAY_EN
  ,
  output logic [6:0]       seg
`endif
);

  if ((DELAY < 1) || (DELAY > ((1 << CNT_W) - 1))) begin : g_bad_delay
    $error("bath_transit_timer: DELAY outside 1..2^CNT_W-1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("bath_transit_timer: DIV must be >= 1");
  end

  localparam bit KEEP = (STICKY != 0);

  state_t           state;
  logic [REQ_W-1:0] pend;
  logic             tick;
  logic             clear_c;

  // Prescaler runs only in COUNT, so it is zero on the entry edge
  assign clear_c = (state != COUNT);

  bath_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear_c),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pend      <= REQ_NONE;
      count     <= '0;
      departing <= 1'b0;
      arriving  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          case (req)
            REQ_ARR, REQ_DEP: begin
              pend  <= req;
              count <= '0;
              busy  <= 1'b1;
              state <= COUNT;
            end
            REQ_NONE, REQ_BAD: ;
          endcase
        end
        COUNT: begin
          if (req != pend) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (tick) begin
            count <= count + CNT_W'(1);
            if ((count + CNT_W'(1)) == CNT_W'(DELAY)) begin
              state     <= HOLD;
              busy      <= 1'b0;
              departing <= pend[1];
              arriving  <= pend[0];
              done      <= 1'b1;
            end
          end
        end
        HOLD: begin
          // count stays at DELAY; any change of request abandons the qualification
          if (req != pend) begin
            state <= IDLE;
            count <= '0;
            if (!KEEP) begin
              departing <= 1'b0;
              arriving  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BATH_TIMER_DISPLAY_EN
  logic [3:0] nib_c;
  assign nib_c = 4'(count);

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'h7F;
    unique case (nib_c)
      4'h0: seg = ~7'h3F;
      4'h1: seg = ~7'h06;
      4'h2: seg = ~7'h5B;
      4'h3: seg = ~7'h4F;
      4'h4: seg = ~7'h66;
      4'h5: seg = ~7'h6D;
      4'h6: seg = ~7'h7D;
      4'h7: seg = ~7'h07;
      4'h8: seg = ~7'h7F;
      4'h9: seg = ~7'h6F;
      4'hA: seg = ~7'h77;
      4'hB: seg = ~7'h7C;
      4'hC: seg = ~7'h39;
      4'hD: seg = ~7'h5E;
      4'hE: seg = ~7'h79;
      4'hF: seg = ~7'h71;
      default: seg = 7'h7F;
    endcase
  end
`endif

endmodule

// File: tb/tb_bath_transit_timer.sv
// Directed bench: default, sticky and divide-by-4 instances share clock, reset and req.
module tb_bath_transit_timer;
  import bath_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;

  logic       dep0, arr0, busy0, done0;
  logic [3:0] cnt0;
  logic       dep_s, arr_s, busy_s, done_s;
  logic [3:0] cnt_s;
  logic       dep_d, arr_d, busy_d, done_d;
  logic [3:0] cnt_d;
`ifdef BATH_TIMER_DISPLAY_EN
  logic [6:0] seg0, seg_s, seg_d;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bath_transit_timer u_dut (
    .clk(clk), .reset(reset), .req(req),
    .departing(dep0), .arriving(arr0), .count(cnt0), .busy(busy0), .done(done0)
`ifdef BATH_TIMER_DISPLAY_EN
    , .seg(seg0)
`endif
  );

  bath_transit_timer #(.STICKY(1)) u_sticky (
    .clk(clk), .reset(reset), .req(req),
    .departing(dep_s), .arriving(arr_s), .count(cnt_s), .busy(busy_s), .done(done_s)
`ifdef BATH_TIMER_DISPLAY_EN
    , .seg(seg_s)
`endif
  );

  bath_transit_timer #(.DIV(4)) u_div (
    .clk(clk), .reset(reset), .req(req),
    .departing(dep_d), .arriving(arr_d), .count(cnt_d), .busy(busy_d), .done(done_d)
`ifdef BATH_TIMER_DISPLAY_EN
    , .seg(seg_d)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    req = REQ_NONE;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset values while reset is held
    req = REQ_NONE;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_state", {27'd0, busy0, done0, dep0, arr0, 1'b0}, 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Hold arrive: five ticks then qualification
    do_reset();
    req = REQ_ARR;
    @(negedge clk);
    chk("arr_entry_busy", 32'(busy0), 32'd1);
    chk("arr_entry_count", 32'(cnt0), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("arr_count_%0d", k), 32'(cnt0), 32'(k));
      chk($sformatf("arr_busy_%0d", k), 32'(busy0), 32'd1);
      chk($sformatf("arr_early_%0d", k), {30'd0, arr0, done0}, 32'd0);
    end
    @(negedge clk);
    chk("arr_qual_arriving", 32'(arr0), 32'd1);
    chk("arr_qual_done", 32'(done0), 32'd1);
    chk("arr_qual_busy", 32'(busy0), 32'd0);
    chk("arr_qual_count", 32'(cnt0), 32'd5);
    chk("arr_qual_departing", 32'(dep0), 32'd0);
    @(negedge clk);
    chk("arr_done_one_cycle", 32'(done0), 32'd0);
    chk("arr_count_saturates", 32'(cnt0), 32'd5);
    chk("arr_sticky_qual", 32'(arr_s), 32'd1);

    // Reverse to depart: drop on change edge, depart six cycles later
    req = REQ_DEP;
    @(negedge clk);
    chk("rev_arriving_drops", 32'(arr0), 32'd0);
    chk("rev_count_clear", 32'(cnt0), 32'd0);
    chk("rev_busy_idle", 32'(busy0), 32'd0);
    chk("rev_sticky_keeps", 32'(arr_s), 32'd1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk($sformatf("rev_dep_%0d", j), 32'(dep0), 32'(j == 6));
      chk($sformatf("rev_arr_%0d", j), 32'(arr0), 32'd0);
      chk($sformatf("rev_done_%0d", j), 32'(done0), 32'(j == 6));
      chk($sformatf("rev_sticky_arr_%0d", j), 32'(arr_s), 32'(j < 6));
      chk($sformatf("rev_sticky_dep_%0d", j), 32'(dep_s), 32'(j == 6));
    end

    // Short depart request abandoned before qualifying
    do_reset();
    req = REQ_DEP;
    @(negedge clk);
    @(negedge clk);
    chk("short_count_1", 32'(cnt0), 32'd1);
    @(negedge clk);
    chk("short_count_2", 32'(cnt0), 32'd2);
    req = REQ_NONE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("short_count_clr_%0d", k), 32'(cnt0), 32'd0);
      chk($sformatf("short_outs_%0d", k), {29'd0, busy0, dep0, done0}, 32'd0);
    end

    // Invalid request keeps the block idle
    do_reset();
    req = REQ_BAD;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("bad_%0d", k), {25'd0, busy0, dep0, arr0, cnt0}, 32'd0);
    end

    // Divide-by-4: count every 4 cycles, arrive 20 cycles after entry
    do_reset();
    req = REQ_ARR;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      chk($sformatf("div_count_%0d", k), 32'(cnt_d), (k / 4 > 5) ? 32'd5 : 32'(k / 4));
      chk($sformatf("div_arr_%0d", k), 32'(arr_d), 32'(k >= 20));
      chk($sformatf("div_done_%0d", k), 32'(done_d), 32'(k == 20));
    end

    // Asynchronous reset mid-count
    do_reset();
    req = REQ_ARR;
    repeat (4) @(negedge clk);
    chk("async_pre_count", 32'(cnt0), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_count", 32'(cnt0), 32'd0);
    chk("async_outs", {28'd0, busy0, done0, dep0, arr0}, 32'd0);
    @(negedge clk);
    chk("async_hold_count", 32'(cnt0), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("async_restart_busy", 32'(busy0), 32'd1);
    chk("async_restart_count0", 32'(cnt0), 32'd0);
    @(negedge clk);
    chk("async_restart_count1", 32'(cnt0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
